// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit that owns HI/LO.
package muldiv_unit_pkg;
  localparam int MD_XLEN = 32;
  localparam int ITER    = 32;
  localparam int CNT_W   = $clog2(ITER);

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic op_is_signed(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction
endpackage

// File: rtl/muldiv_signfix.sv
// All sign handling: operand magnitudes and result/remainder signs at capture,
// and the final negation of the raw unsigned result before it lands in HI/LO.
module muldiv_signfix
  import muldiv_unit_pkg::*;
(
  input  logic [MD_XLEN-1:0]   a,
  input  logic [MD_XLEN-1:0]   b,
  input  logic                 is_signed,
  output logic [MD_XLEN-1:0]   mag_a,
  output logic [MD_XLEN-1:0]   mag_b,
  output logic                 res_neg,
  output logic                 rem_neg,
  input  logic                 is_div,
  input  logic                 fix_res_neg,
  input  logic                 fix_rem_neg,
  input  logic [2*MD_XLEN-1:0] raw,
  output logic [2*MD_XLEN-1:0] fixed
);
  localparam int MSB = MD_XLEN - 1;

  assign mag_a   = (is_signed && a[MSB]) ? -a : a;
  assign mag_b   = (is_signed && b[MSB]) ? -b : b;
  assign res_neg = is_signed && (a[MSB] ^ b[MSB]);
  assign rem_neg = is_signed && a[MSB];

  // Divide keeps {remainder, quotient} and fixes each half independently
  always_comb begin
    fixed = raw;
    if (is_div) begin
      fixed[2*MD_XLEN-1:MD_XLEN] = fix_rem_neg ? -raw[2*MD_XLEN-1:MD_XLEN] : raw[2*MD_XLEN-1:MD_XLEN];
      fixed[MD_XLEN-1:0]         = fix_res_neg ? -raw[MD_XLEN-1:0] : raw[MD_XLEN-1:0];
    end else if (fix_res_neg) begin
      fixed = -raw;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU responder with HI/LO ownership: 32 shift-add or
// restoring-divide steps on a 64-bit register, then one FIX cycle that writes HI/LO.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);
  md_state_e         state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              is_div_q, res_neg_q, rem_neg_q, div0_q;
  logic [XLEN-1:0]   opnd_q;   // multiplicand or divisor
  logic [2*XLEN-1:0] dp_q;     // {acc, multiplier} or {remainder, dividend/quotient}

  logic [XLEN-1:0]   mag_a, mag_b;
  logic              res_neg, rem_neg;
  logic [2*XLEN-1:0] fixed;
  logic              div_zero;

  assign div_zero = op[1] && (B == '0);
  assign busy     = (state != IDLE);

  muldiv_signfix u_signfix (
    .a           (A),
    .b           (B),
    .is_signed   (op_is_signed(md_op_e'(op))),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .res_neg     (res_neg),
    .rem_neg     (rem_neg),
    .is_div      (is_div_q),
    .fix_res_neg (res_neg_q),
    .fix_rem_neg (rem_neg_q),
    .raw         (dp_q),
    .fixed       (fixed)
  );

  // One iteration step of either algorithm
  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] dp_step;

  always_comb begin
    mul_sum  = {1'b0, dp_q[2*XLEN-1:XLEN]} + (dp_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {dp_q[2*XLEN-1:XLEN], dp_q[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, opnd_q});
    div_diff = div_sh[XLEN-1:0] - opnd_q;
    if (is_div_q)
      dp_step = div_ge ? {div_diff, dp_q[XLEN-2:0], 1'b1}
                       : {div_sh[XLEN-1:0], dp_q[XLEN-2:0], 1'b0};
    else
      dp_step = {mul_sum, dp_q[XLEN-1:1]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div_zero ? FIX : RUN;
      RUN:     if (cnt == CNT_W'(ITER - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      opnd_q    <= '0;
      dp_q      <= '0;
      HI        <= '0;
      LO        <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div_q  <= op[1];
            res_neg_q <= res_neg;
            rem_neg_q <= rem_neg;
            div0_q    <= div_zero;
            cnt       <= '0;
            opnd_q    <= op[1] ? mag_b : mag_a;
            dp_q      <= {{XLEN{1'b0}}, (op[1] ? mag_a : mag_b)};
          end else begin
            if (mthi) HI <= wdata;
            if (mtlo) LO <= wdata;
          end
        end
        RUN: begin
          dp_q <= dp_step;
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (!div0_q) {HI, LO} <= fixed;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of arithmetic cases plus hand
// sequences for moves, divide by zero, busy-time interference and mid-op reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] A = '0, B = '0, wdata = '0;
  logic        busy, done;
  logic [31:0] HI, LO;

  int n_pass = 0, n_total = 0;

  always #5 CLK = ~CLK;

  muldiv_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic mlo, input logic [31:0] wd);
    start = 1'b1; op = o; A = a; B = b; mtlo = mlo; wdata = wd;
    @(posedge CLK); #1;
    start = 1'b0; mtlo = 1'b0;
  endtask

  // Returns the cycle number (1 = cycle right after the accepting edge) in which done
  // is seen; bok drops if busy is low before done or high in the done cycle.
  task automatic wait_done(input int n0, output int lat, output bit bok);
    lat = -1;
    bok = 1'b1;
    for (int n = n0; n <= 200; n++) begin
      @(negedge CLK);
      if (done) begin
        lat = n;
        if (busy) bok = 1'b0;
        break;
      end
      if (!busy) bok = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit bok;

    vecs[0] = '{"mult_7_m3",    MD_MULT,  32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{"multu_max",    MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{"divu_7_2",     MD_DIVU,  32'h7,        32'h2,        32'h1,        32'h3};
    vecs[3] = '{"div_m7_2",     MD_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{"div_min_m1",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
    vecs[5] = '{"div_7_m2",     MD_DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD};
    vecs[6] = '{"mult_min_min", MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
    vecs[7] = '{"divu_max_16",  MD_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h33;
    @(posedge CLK); #1;
    mthi = 1'b0; mtlo = 1'b0;
    @(negedge CLK);
    check("mt_both_hi", HI, 32'h33);
    check("mt_both_lo", LO, 32'h33);
    check("mt_no_done", done, 0);

    // Back-to-back: each launch drives start in the cycle done is high
    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, '0);
      wait_done(1, lat, bok);
      check({vecs[i].name, "_lat"}, lat, 34);
      check({vecs[i].name, "_busy"}, bok, 1);
      check({vecs[i].name, "_hi"}, HI, vecs[i].hi);
      check({vecs[i].name, "_lo"}, LO, vecs[i].lo);
    end

    @(posedge CLK); #1;
    mthi = 1'b1; wdata = 32'h11;
    @(posedge CLK); #1;
    mthi = 1'b0;
    @(negedge CLK);
    check("mthi_hi", HI, 32'h11);
    mtlo = 1'b1; wdata = 32'h22;
    @(posedge CLK); #1;
    mtlo = 1'b0;
    @(negedge CLK);
    check("mtlo_lo", LO, 32'h22);
    check("mtlo_hi_kept", HI, 32'h11);

    // Divide by zero, with an MTLO that start must override
    launch(MD_DIV, 32'd5, 32'd0, 1'b1, 32'h99);
    wait_done(1, lat, bok);
    check("div0_lat", lat, 2);
    check("div0_busy", bok, 1);
    check("div0_hi", HI, 32'h11);
    check("div0_lo", LO, 32'h22);

    // start + MTLO while busy must both be ignored
    launch(MD_MULT, 32'd3, 32'd4, 1'b0, '0);
    start = 1'b1; op = MD_DIV; A = 32'd100; B = 32'd7; mtlo = 1'b1; wdata = 32'h55;
    @(posedge CLK); #1;
    start = 1'b0; mtlo = 1'b0;
    wait_done(2, lat, bok);
    check("busy_ign_lat", lat, 34);
    check("busy_ign_busy", bok, 1);
    check("busy_ign_hi", HI, 0);
    check("busy_ign_lo", LO, 12);
    @(negedge CLK);
    check("done_pulse_width", done, 0);
    check("no_queued_op", busy, 0);

    // Asynchronous reset in the middle of an operation
    @(posedge CLK); #1;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAA;
    @(posedge CLK); #1;
    mthi = 1'b0; mtlo = 1'b0;
    launch(MD_MULT, 32'd3, 32'd4, 1'b0, '0);
    repeat (10) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hi", HI, 0);
    check("arst_lo", LO, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    launch(MD_MULTU, 32'd2, 32'd3, 1'b0, '0);
    wait_done(1, lat, bok);
    check("post_rst_lat", lat, 34);
    check("post_rst_hi", HI, 0);
    check("post_rst_lo", LO, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
